// File: rtl/iic_pkg.sv
// Shared types and constants for the IIC transaction sequencer and its byte-engine handshake.
package iic_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_WAIT,
        ST_DATA,
        ST_DATA_WAIT,
        ST_RX_HOLD,
        ST_STOP,
        ST_STOP_WAIT,
        ST_FIN
    } state_t;

    // First byte on the wire: 7-bit device address followed by the direction bit.
    function automatic logic [DATA_W-1:0] addr_byte(input logic [ADDR_W-1:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/iic_xfer_ctrl_if.sv
// Request, tx/rx byte streams and iic_core handshake of the transaction sequencer.
interface iic_xfer_ctrl_if;
    import iic_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_rw;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              done;
    logic              err;
    logic              core_start;
    logic              core_stop;
    logic              core_rw;
    logic [DATA_W-1:0] core_din;
    logic              core_busy;
    logic              core_sending;
    logic [DATA_W-1:0] core_dout;

    modport master (
        input  req_valid, req_addr, req_rw, req_len, tx_data, tx_valid, rx_ready,
               core_busy, core_sending, core_dout,
        output req_ready, tx_ready, rx_data, rx_valid, done, err,
               core_start, core_stop, core_rw, core_din
    );

    modport slave (
        output req_valid, req_addr, req_rw, req_len, tx_data, tx_valid, rx_ready,
               core_busy, core_sending, core_dout,
        input  req_ready, tx_ready, rx_data, rx_valid, done, err,
               core_start, core_stop, core_rw, core_din
    );

endinterface

// File: rtl/iic_timeout_cnt.sv
// Per-byte watchdog: counts wait cycles since the last clear and flags the TIMEOUT-th one.
module iic_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Counter holds k-1 during the k-th wait cycle.
    assign expired_c = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/iic_xfer_ctrl.sv
// Sequences one IIC transaction (address byte, N data bytes, STOP) onto iic_core.
module iic_xfer_ctrl
    import iic_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input logic             clock,
    input logic             reset_n,
    iic_xfer_ctrl_if.master bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    logic              tmo_clr, tmo_en, tmo_expired_c;
    logic              req_ready_c, tx_ready_c, start_c, stop_c, core_rw_c;
    logic [DATA_W-1:0] din_c;

    iic_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr       (tmo_clr),
        .en        (tmo_en),
        .expired_c (tmo_expired_c)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        rem_d       = rem_q;
        err_d       = err_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        tmo_clr     = 1'b0;
        tmo_en      = 1'b0;
        req_ready_c = 1'b0;
        tx_ready_c  = 1'b0;
        start_c     = 1'b0;
        stop_c      = 1'b0;
        core_rw_c   = 1'b0;
        din_c       = '0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready_c = !bus.core_sending;
                if (bus.req_valid && req_ready_c) begin
                    addr_d  = bus.req_addr;
                    rw_d    = bus.req_rw;
                    rem_d   = bus.req_len;
                    err_d   = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                start_c = 1'b1;
                din_c   = addr_byte(addr_q, rw_q);
                tmo_clr = 1'b1;
                state_d = ST_ADDR_WAIT;
            end
            ST_ADDR_WAIT: begin
                tmo_en = 1'b1;
                if (!bus.core_busy) begin
                    state_d = (rem_q == '0) ? ST_STOP : ST_DATA;
                end else if (tmo_expired_c) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_DATA: begin
                if (rw_q == RW_WRITE) begin
                    // Core sits in its wait condition (SCK low) until the next write byte shows up.
                    if (bus.tx_valid) begin
                        tx_ready_c = 1'b1;
                        start_c    = 1'b1;
                        din_c      = bus.tx_data;
                        rem_d      = rem_q - LEN_W'(1);
                        tmo_clr    = 1'b1;
                        state_d    = ST_DATA_WAIT;
                    end
                end else begin
                    start_c   = 1'b1;
                    core_rw_c = 1'b1;
                    rem_d     = rem_q - LEN_W'(1);
                    tmo_clr   = 1'b1;
                    state_d   = ST_DATA_WAIT;
                end
            end
            ST_DATA_WAIT: begin
                tmo_en = 1'b1;
                if (!bus.core_busy) begin
                    if (rw_q == RW_WRITE) begin
                        state_d = (rem_q == '0) ? ST_STOP : ST_DATA;
                    end else begin
                        rx_data_d  = bus.core_dout;
                        rx_valid_d = 1'b1;
                        state_d    = ST_RX_HOLD;
                    end
                end else if (tmo_expired_c) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_RX_HOLD: begin
                if (bus.rx_ready) begin
                    rx_valid_d = 1'b0;
                    state_d    = (rem_q == '0) ? ST_STOP : ST_DATA;
                end
            end
            ST_STOP: begin
                stop_c  = 1'b1;
                tmo_clr = 1'b1;
                state_d = ST_STOP_WAIT;
            end
            ST_STOP_WAIT: begin
                tmo_en = 1'b1;
                if (!bus.core_busy && !bus.core_sending) begin
                    state_d = ST_FIN;
                end else if (tmo_expired_c) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.tx_ready   = tx_ready_c;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.done       = (state_q == ST_FIN);
    assign bus.err        = err_q;
    assign bus.core_start = start_c;
    assign bus.core_stop  = stop_c;
    assign bus.core_rw    = core_rw_c;
    assign bus.core_din   = din_c;

endmodule

// File: tb/tb_iic_xfer_ctrl.sv
// Bench for iic_xfer_ctrl: vector table of transactions against a behavioural iic_core and start/rx scoreboards.
module tb_iic_xfer_ctrl;
    import iic_pkg::*;

    localparam int unsigned TB_TIMEOUT = 16;
    localparam int unsigned TB_CNT_W   = 8;
    localparam int          BYTE_CYC   = 3;
    localparam int          STOP_CYC   = 2;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [3:0]  len;
        logic [15:0] data;
        int          tx_gap;
        int          rx_gap;
        logic        hang;
        logic [7:0]  exp_ab;
        logic        exp_err;
    } vec_t;

    typedef struct packed {
        logic       rw;
        logic [7:0] din;
    } exp_t;

    logic clock;
    logic reset_n;
    iic_xfer_ctrl_if bus ();

    iic_xfer_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural iic_core: busy rises on the edge that samples start/stop.
    logic       hang, core_release, stopping;
    logic [7:0] rd_byte;
    int         mcnt;
    always @(posedge clock) begin
        if (!reset_n) begin
            bus.core_busy <= 1'b0; bus.core_sending <= 1'b0; bus.core_dout <= 8'h00;
            stopping <= 1'b0; mcnt <= 0;
        end else if (core_release) begin
            bus.core_busy <= 1'b0; bus.core_sending <= 1'b0; stopping <= 1'b0;
        end else if (bus.core_start) begin
            bus.core_busy <= 1'b1; bus.core_sending <= 1'b1; mcnt <= BYTE_CYC;
            if (bus.core_rw) bus.core_dout <= rd_byte;
        end else if (bus.core_stop) begin
            bus.core_busy <= 1'b1; stopping <= 1'b1; mcnt <= STOP_CYC;
        end else if (bus.core_busy && !hang) begin
            if (mcnt == 0) begin
                bus.core_busy <= 1'b0;
                if (stopping) begin bus.core_sending <= 1'b0; stopping <= 1'b0; end
            end else begin
                mcnt <= mcnt - 1;
            end
        end
    end

    int   n_checks, n_fail, cyc;
    int   n_start, n_rd_start, n_stop, n_txr, n_rxh, n_done, done_cyc, last_start_cyc;
    logic last_err, prev_start, prev_stop, prev_done, prev_rxv, prev_rxr;
    logic [7:0] prev_rxd;
    exp_t exp_q [$];
    logic [7:0] exp_rx [$];
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        cyc++;
        if (reset_n) begin
            if (bus.core_start || bus.core_stop)
                check("start_stop_exclusive", 32'(bus.core_start & bus.core_stop), 0);
            if (bus.core_start) begin
                n_start++; last_start_cyc = cyc;
                if (bus.core_rw) n_rd_start++;
                check("start_width", 32'(prev_start), 0);
                check("start_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("core_rw", 32'(bus.core_rw), 32'(e.rw));
                    if (!e.rw) check("core_din", 32'(bus.core_din), 32'(e.din));
                    else check("read_start_rx_pending", 32'(bus.rx_valid), 0);
                end
            end
            if (bus.core_stop) begin
                n_stop++;
                check("stop_width", 32'(prev_stop), 0);
            end
            if (bus.tx_ready) n_txr++;
            if (bus.rx_valid && bus.rx_ready) begin
                n_rxh++;
                check("rx_expected", 32'(exp_rx.size() != 0), 1);
                if (exp_rx.size() != 0) check("rx_data", 32'(bus.rx_data), 32'(exp_rx.pop_front()));
            end
            if (prev_rxv && !prev_rxr) begin
                check("rx_hold_valid", 32'(bus.rx_valid), 1);
                check("rx_hold_data", 32'(bus.rx_data), 32'(prev_rxd));
            end
            if (bus.done) begin
                n_done++; done_cyc = cyc; last_err = bus.err;
                check("done_width", 32'(prev_done), 0);
            end
            prev_start = bus.core_start; prev_stop = bus.core_stop; prev_done = bus.done;
            prev_rxv = bus.rx_valid; prev_rxr = bus.rx_ready; prev_rxd = bus.rx_data;
        end else begin
            prev_start = 1'b0; prev_stop = 1'b0; prev_done = 1'b0;
            prev_rxv = 1'b0; prev_rxr = 1'b0; prev_rxd = 8'h00;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mk(input logic [6:0] a, input logic rw, input logic [3:0] len,
                                input logic [15:0] d, input int txg, input int rxg,
                                input logic hg, input logic [7:0] ab, input logic er);
        vec_t v;
        v.addr = a; v.rw = rw; v.len = len; v.data = d; v.tx_gap = txg; v.rx_gap = rxg;
        v.hang = hg; v.exp_ab = ab; v.exp_err = er;
        return v;
    endfunction

    task automatic send_request(input logic [6:0] a, input logic rw, input logic [3:0] len);
        for (int c = 0; c < 100 && !bus.req_ready; c++) tick();
        check("req_ready_wait", 32'(bus.req_ready), 1);
        bus.req_addr = a; bus.req_rw = rw; bus.req_len = len; bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic send_tx(input logic [7:0] b);
        int t0;
        bus.tx_data = b; bus.tx_valid = 1'b1;
        exp_q.push_back(exp_t'{rw: 1'b0, din: b});
        t0 = n_txr;
        for (int c = 0; c < 100 && n_txr == t0; c++) tick();
        bus.tx_valid = 1'b0;
        check("tx_handshake", n_txr - t0, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int d_start, d_rd, d_stop, d_txr, d_rxh, d_done, s0, p0;
        int len;
        len = int'(v.len);
        d_start = n_start; d_rd = n_rd_start; d_stop = n_stop;
        d_txr = n_txr; d_rxh = n_rxh; d_done = n_done;
        rd_byte = v.data[7:0];
        hang = v.hang;
        exp_q.push_back(exp_t'{rw: 1'b0, din: v.exp_ab});
        if (v.rw == RW_READ) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back(exp_t'{rw: 1'b1, din: 8'h00});
                exp_rx.push_back(v.data[8*i +: 8]);
            end
        end
        send_request(v.addr, v.rw, v.len);

        if (v.rw != RW_READ && !v.hang) begin
            for (int i = 0; i < len; i++) begin
                if (i > 0 && v.tx_gap > 0) begin
                    s0 = n_start;
                    repeat (v.tx_gap) tick();
                    check("tx_stall_no_start", n_start - s0, 0);
                end
                send_tx(v.data[8*i +: 8]);
            end
        end

        if (v.rw == RW_READ) begin
            for (int i = 0; i < len; i++) begin
                for (int c = 0; c < 100 && !bus.rx_valid; c++) tick();
                check("rx_valid_wait", 32'(bus.rx_valid), 1);
                if (v.rx_gap > 0) begin
                    s0 = n_start; p0 = n_stop;
                    repeat (v.rx_gap) tick();
                    check("rx_stall_no_start_stop", (n_start - s0) + (n_stop - p0), 0);
                end
                if (i + 1 < len) rd_byte = v.data[8*(i+1) +: 8];
                bus.rx_ready = 1'b1;
                tick();
                bus.rx_ready = 1'b0;
                check("rx_valid_drop", 32'(bus.rx_valid), 0);
                check("rx_data_keep", 32'(bus.rx_data), 32'(v.data[8*i +: 8]));
            end
        end

        for (int c = 0; c < 300 && n_done == d_done; c++) tick();
        check("done_seen", n_done - d_done, 1);
        check("err", 32'(last_err), 32'(v.exp_err));
        check("start_count", n_start - d_start, v.hang ? 1 : 1 + len);
        check("read_start_count", n_rd_start - d_rd, (v.rw == RW_READ) ? len : 0);
        check("stop_count", n_stop - d_stop, v.hang ? 0 : 1);
        check("tx_ready_pulses", n_txr - d_txr, (v.rw != RW_READ && !v.hang) ? len : 0);
        check("rx_handshakes", n_rxh - d_rxh, (v.rw == RW_READ) ? len : 0);
        check("start_queue_drained", 32'(exp_q.size()), 0);
        check("rx_queue_drained", 32'(exp_rx.size()), 0);

        if (v.hang) begin
            check("timeout_latency", done_cyc - last_start_cyc, int'(TB_TIMEOUT) + 1);
            check("req_ready_while_sending", 32'(bus.req_ready), 0);
            core_release = 1'b1;
            tick();
            core_release = 1'b0;
            hang = 1'b0;
            check("req_ready_after_release", 32'(bus.req_ready), 1);
        end
        exp_q.delete();
        exp_rx.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 1);
        check({tag, "_outputs_zero"},
              32'({bus.tx_ready, bus.rx_valid, bus.rx_data, bus.done, bus.err,
                   bus.core_start, bus.core_stop, bus.core_rw, bus.core_din}), 0);
    endtask

    initial begin
        int d_done;
        n_checks = 0; n_fail = 0; cyc = 0;
        n_start = 0; n_rd_start = 0; n_stop = 0; n_txr = 0; n_rxh = 0; n_done = 0;
        done_cyc = 0; last_start_cyc = 0; last_err = 1'b0;
        prev_start = 1'b0; prev_stop = 1'b0; prev_done = 1'b0;
        prev_rxv = 1'b0; prev_rxr = 1'b0; prev_rxd = 8'h00;
        hang = 1'b0; core_release = 1'b0; rd_byte = 8'h00;
        reset_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_rw = 1'b0; bus.req_len = '0;
        bus.tx_valid = 1'b0; bus.tx_data = '0; bus.rx_ready = 1'b0;

        vecs[0] = mk(7'h50, 1'b0, 4'd2, 16'h3412,  0,  0, 1'b0, 8'hA0, 1'b0);
        vecs[1] = mk(7'h48, 1'b1, 4'd1, 16'h003C,  0,  3, 1'b0, 8'h91, 1'b0);
        vecs[2] = mk(7'h27, 1'b0, 4'd0, 16'h0000,  0,  0, 1'b0, 8'h4E, 1'b0);
        vecs[3] = mk(7'h33, 1'b0, 4'd2, 16'hA55A, 20,  0, 1'b0, 8'h66, 1'b0);
        vecs[4] = mk(7'h11, 1'b1, 4'd2, 16'h7EC3,  0, 10, 1'b0, 8'h23, 1'b0);
        vecs[5] = mk(7'h50, 1'b0, 4'd1, 16'h00FF,  0,  0, 1'b1, 8'hA0, 1'b1);
        vecs[6] = mk(7'h7F, 1'b0, 4'd0, 16'h0000,  0,  0, 1'b0, 8'hFE, 1'b0);

        repeat (3) tick();
        check_reset_outputs("por");
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while the first write byte is still on the wire.
        d_done = n_done;
        exp_q.push_back(exp_t'{rw: 1'b0, din: 8'h54});
        send_request(7'h2A, 1'b0, 4'd2);
        send_tx(8'h77);
        check("busy_before_reset", 32'(bus.core_busy), 1);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        repeat (5) tick();
        check("no_done_after_reset", n_done - d_done, 0);
        exp_q.delete();

        run_vec(vecs[6]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
